hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_scoreboard_cnt_slot.sv | 49 ++++
 rtl/hazard_scoreboard.sv | 107 ++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types, default latencies and the writer-latency helper
//               for the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int DEF_REG_ADDR_W = 2;
    localparam int DEF_LOAD_LAT   = 1;
    localparam int DEF_ALU_LAT    = 0;

    typedef logic [DEF_REG_ADDR_W-1:0] reg_addr_t;

    // Number of cycles the written register stays unavailable after issue.
    function automatic int unsigned haz_lat(input logic        is_load,
                                            input int unsigned load_lat,
                                            input int unsigned alu_lat);
        return is_load ? load_lat : alu_lat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_cnt_slot.sv
// ============================================================================
// Module      : haz_cnt_slot
// Description : Countdown counter for one architectural register. Flush
//               clears, a new writer loads its latency, otherwise the counter
//               runs down to zero and holds there.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module haz_cnt_slot #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: flush beats a new writer, a new writer beats the decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (load_en) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage RAW/WAW hazard detector built on a per-register
//               countdown scoreboard. Supports arbitrary writer latency up to
//               LOAD_LAT; LOAD_LAT=1/ALU_LAT=0 gives the classic one-bubble
//               load-use stall.
//               Optional macro HAZ_PERF_CNT_EN adds the stall_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int LOAD_LAT   = DEF_LOAD_LAT,
    parameter int ALU_LAT    = DEF_ALU_LAT,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic                  src1_en,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  src2_en,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  dest_en,
    input  logic                  is_load,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int NREG = 2**REG_ADDR_W;

    logic [CNT_W-1:0] cnt [NREG];
    logic [CNT_W-1:0] lat;
    logic             raw;
    logic             waw;
    logic             fire;
    logic [NREG-1:0]  slot_load;

    // Hazard check against the pre-update counters, so an instruction never
    // sees its own destination write as a hazard.
    always_comb begin
        lat   = CNT_W'(haz_lat(is_load, int'(LOAD_LAT), int'(ALU_LAT)));
        raw   = (src1_en && (cnt[src1] != '0)) || (src2_en && (cnt[src2] != '0));
        waw   = dest_en && (cnt[dest] > lat);
        stall = issue_valid && !flush && (raw || waw);
        fire  = issue_valid && !stall && !flush;
    end

    // Busy whenever any register still has a write in flight.
    always_comb begin
        busy = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            busy = busy | (cnt[r] != '0);
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_slot
        assign slot_load[gi] = fire && dest_en && (dest == REG_ADDR_W'(gi));

        haz_cnt_slot #(
            .CNT_W    (CNT_W)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .load_en  (slot_load[gi]),
            .load_val (lat),
            .cnt      (cnt[gi])
        );
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles_d;
    logic [31:0] stall_cycles_q;

    // Saturating count of stalled cycles; flush does not clear it.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Stall-cycle counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire
